// File: rtl/xm23_pkg.sv
// xm23_pkg: PSW bit indices, arithmetic flag mask and subtract sequencer state type
package xm23_pkg;
  localparam int PSW_C = 0;
  localparam int PSW_Z = 1;
  localparam int PSW_N = 2;
  localparam int PSW_V = 4;
  localparam logic [15:0] PSW_ARITH_MSK = 16'h0017;
  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} sub_seq_state_t;
endpackage

// File: rtl/alu_sbc.sv
// alu_sbc: 16-bit subtract-with-borrow; a - b - bin -> difference d, borrow-out bout, signed overflow v
module alu_sbc (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        bin,
  output logic [15:0] d,
  output logic        bout,
  output logic        v
);
  assign {bout, d} = {1'b0, a} - {1'b0, b} - {16'b0, bin};
  assign v = (a[15] != b[15]) && (d[15] != a[15]);
endmodule

// File: rtl/alu_sub_seq.sv
// alu_sub_seq: multi-word subtract sequencer; start/num_words launch, op_valid/op_ready operands in, res_valid/res_ready results out, done with psw_out/psw_msk flag update
module alu_sub_seq
  import xm23_pkg::*;
#(
  parameter int MAX_WORDS = 4,
  parameter int CNT_W = $clog2(MAX_WORDS + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] num_words,
  output logic             busy,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [15:0]      a_in,
  input  logic [15:0]      b_in,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [15:0]      result,
  output logic             done,
  output logic [15:0]      psw_out,
  output logic [15:0]      psw_msk
);
  sub_seq_state_t state, state_nx;
  logic [CNT_W-1:0] remaining, len;
  logic [15:0] d;
  logic borrow, zacc, n, v, bout, d_v, op_fire, last;
  alu_sbc u_sbc (.a(a_in), .b(b_in), .bin(borrow), .d(d), .bout(bout), .v(d_v));
  assign len = num_words == '0 ? CNT_W'(1) : num_words > CNT_W'(MAX_WORDS) ? CNT_W'(MAX_WORDS) : num_words;
  assign op_fire = op_valid && op_ready;
  assign last = remaining == CNT_W'(1);
  always_comb begin
    state_nx = state;
    op_ready = state == RUN && (!res_valid || res_ready);
    busy = state != IDLE;
    done = state == DONE;
    psw_out = '0;
    psw_msk = done ? PSW_ARITH_MSK : '0;
    state_nx = state == IDLE ? (start ? RUN : IDLE)
             : state == RUN ? (op_fire && last ? FLUSH : RUN)
             : state == FLUSH ? (res_valid && res_ready ? DONE : FLUSH)
             : IDLE;
    if (done) begin
      psw_out[PSW_C] = ~borrow;
      psw_out[PSW_Z] = zacc;
      psw_out[PSW_N] = n;
      psw_out[PSW_V] = v;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      remaining <= '0;
      borrow <= 1'b0;
      zacc <= 1'b1;
      n <= 1'b0;
      v <= 1'b0;
      result <= '0;
      res_valid <= 1'b0;
    end else begin
      state <= state_nx;
      res_valid <= op_fire || (res_valid && !res_ready);
      if (state == IDLE && start) begin
        remaining <= len;
        borrow <= 1'b0;
        zacc <= 1'b1;
      end
      if (op_fire) begin
        result <= d;
        borrow <= bout;
        zacc <= zacc && d == 16'h0000;
        remaining <= remaining - CNT_W'(1);
        if (last) begin
          n <= d[15];
          v <= d_v;
        end
      end
    end
  end
endmodule

// File: tb/tb_alu_sub_seq.sv
// tb_alu_sub_seq: directed self-checking bench for alu_sub_seq
module tb_alu_sub_seq;
  logic clk = 0, rst_n = 0, start = 0, op_valid = 0, res_ready = 1;
  logic [2:0] num_words = 0;
  logic [15:0] a_in = 0, b_in = 0;
  logic busy, op_ready, res_valid, done;
  logic [15:0] result, psw_out, psw_msk;
  int checks = 0, errors = 0;
  logic [15:0] va [8], vb [8], got [8];
  logic [15:0] got_psw, got_msk;
  int nres, ndone, consumed, stalls, stall_bad;
  alu_sub_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_words(num_words), .busy(busy),
    .op_valid(op_valid), .op_ready(op_ready), .a_in(a_in), .b_in(b_in),
    .res_valid(res_valid), .res_ready(res_ready), .result(result),
    .done(done), .psw_out(psw_out), .psw_msk(psw_msk)
  );
  always #5 clk = ~clk;
  task automatic run_op(input int nw, input int k, input bit stall_en);
    int after;
    nres = 0; ndone = 0; consumed = 0; stalls = 0; stall_bad = 0; after = 0;
    got_psw = 16'hDEAD; got_msk = 16'hDEAD;
    for (int j = 0; j < 8; j++) got[j] = 16'hDEAD;
    @(negedge clk);
    start = 1; num_words = 3'(nw);
    @(negedge clk);
    start = 0;
    for (int c = 0; c < 60; c++) begin
      op_valid = consumed < k;
      a_in = consumed < k ? va[consumed] : 16'h0;
      b_in = consumed < k ? vb[consumed] : 16'h0;
      res_ready = !(stall_en && nres == 1 && stalls < 3);
      #1;
      if (!res_ready) begin stalls++; if (op_ready !== 1'b0) stall_bad++; end
      if (res_valid && res_ready) begin if (nres < 8) got[nres] = result; nres++; end
      if (op_valid && op_ready) consumed++;
      if (done) begin ndone++; got_psw = psw_out; got_msk = psw_msk; end
      if (ndone > 0) after++;
      @(negedge clk);
      if (after >= 3) break;
    end
    op_valid = 0; res_ready = 1;
  endtask
  task automatic test_reset;
    rst_n = 0;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b exp 0", busy); end
    checks++; if (op_ready !== 1'b0) begin errors++; $display("FAIL reset_op_ready: got %b exp 0", op_ready); end
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid: got %b exp 0", res_valid); end
    checks++; if (result !== 16'h0000) begin errors++; $display("FAIL reset_result: got %h exp 0000", result); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b exp 0", done); end
    checks++; if (psw_out !== 16'h0000) begin errors++; $display("FAIL reset_psw_out: got %h exp 0000", psw_out); end
    checks++; if (psw_msk !== 16'h0000) begin errors++; $display("FAIL reset_psw_msk: got %h exp 0000", psw_msk); end
    rst_n = 1;
    @(negedge clk);
  endtask
  task automatic test_single;
    va[0] = 16'h0005; vb[0] = 16'h0003;
    run_op(1, 1, 0);
    checks++; if (got[0] !== 16'h0002) begin errors++; $display("FAIL single_result: got %h exp 0002", got[0]); end
    checks++; if (got_psw !== 16'h0001) begin errors++; $display("FAIL single_psw: got %h exp 0001", got_psw); end
    checks++; if (got_msk !== 16'h0017) begin errors++; $display("FAIL single_msk: got %h exp 0017", got_msk); end
    checks++; if (ndone !== 1) begin errors++; $display("FAIL single_done_count: got %0d exp 1", ndone); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_idle_after: busy got %b exp 0", busy); end
    checks++; if (psw_msk !== 16'h0000) begin errors++; $display("FAIL single_msk_after: got %h exp 0000", psw_msk); end
  endtask
  task automatic test_borrow_chain;
    va[0] = 16'h0000; va[1] = 16'h0001; vb[0] = 16'h0001; vb[1] = 16'h0000;
    run_op(2, 2, 0);
    checks++; if (got[0] !== 16'hFFFF) begin errors++; $display("FAIL chain_r0: got %h exp FFFF", got[0]); end
    checks++; if (got[1] !== 16'h0000) begin errors++; $display("FAIL chain_r1: got %h exp 0000", got[1]); end
    checks++; if (got_psw !== 16'h0001) begin errors++; $display("FAIL chain_psw: got %h exp 0001", got_psw); end
  endtask
  task automatic test_zero_borrow;
    va[0] = 16'h1234; va[1] = 16'h8000; vb[0] = 16'h1234; vb[1] = 16'h8000;
    run_op(2, 2, 0);
    checks++; if (got[0] !== 16'h0000 || got[1] !== 16'h0000) begin errors++; $display("FAIL zero_results: got %h %h exp 0000 0000", got[0], got[1]); end
    checks++; if (got_psw !== 16'h0003) begin errors++; $display("FAIL zero_psw: got %h exp 0003", got_psw); end
    va[0] = 16'h0000; va[1] = 16'h0000; vb[0] = 16'h0001; vb[1] = 16'h0000;
    run_op(2, 2, 0);
    checks++; if (got[0] !== 16'hFFFF || got[1] !== 16'hFFFF) begin errors++; $display("FAIL neg_results: got %h %h exp FFFF FFFF", got[0], got[1]); end
    checks++; if (got_psw !== 16'h0004) begin errors++; $display("FAIL neg_psw: got %h exp 0004", got_psw); end
  endtask
  task automatic test_overflow;
    va[0] = 16'h8000; vb[0] = 16'h0001;
    run_op(1, 1, 0);
    checks++; if (got[0] !== 16'h7FFF) begin errors++; $display("FAIL ovf_result: got %h exp 7FFF", got[0]); end
    checks++; if (got_psw !== 16'h0011) begin errors++; $display("FAIL ovf_psw: got %h exp 0011", got_psw); end
  endtask
  task automatic test_backpressure;
    va[0] = 16'h0010; va[1] = 16'h0000; va[2] = 16'h8000; va[3] = 16'h0001;
    vb[0] = 16'h0011; vb[1] = 16'h0000; vb[2] = 16'h0000; vb[3] = 16'h0002;
    run_op(4, 4, 1);
    checks++; if (got[0] !== 16'hFFFF) begin errors++; $display("FAIL bp_r0: got %h exp FFFF", got[0]); end
    checks++; if (got[1] !== 16'hFFFF) begin errors++; $display("FAIL bp_r1: got %h exp FFFF", got[1]); end
    checks++; if (got[2] !== 16'h7FFF) begin errors++; $display("FAIL bp_r2: got %h exp 7FFF", got[2]); end
    checks++; if (got[3] !== 16'hFFFF) begin errors++; $display("FAIL bp_r3: got %h exp FFFF", got[3]); end
    checks++; if (got_psw !== 16'h0004) begin errors++; $display("FAIL bp_psw: got %h exp 0004", got_psw); end
    checks++; if (stalls !== 3 || stall_bad !== 0) begin errors++; $display("FAIL bp_stall: stalls %0d op_ready_high %0d exp 3 0", stalls, stall_bad); end
    checks++; if (ndone !== 1 || nres !== 4) begin errors++; $display("FAIL bp_counts: done %0d results %0d exp 1 4", ndone, nres); end
  endtask
  task automatic test_clamp;
    va[0] = 16'h0007; vb[0] = 16'h0002; va[1] = 16'h0001; vb[1] = 16'h0001;
    run_op(0, 2, 0);
    checks++; if (got[0] !== 16'h0005 || nres !== 1) begin errors++; $display("FAIL zero_len_result: got %h n=%0d exp 0005 n=1", got[0], nres); end
    checks++; if (consumed !== 1 || got_psw !== 16'h0001) begin errors++; $display("FAIL zero_len_psw: consumed %0d psw %h exp 1 0001", consumed, got_psw); end
    for (int j = 0; j < 6; j++) begin va[j] = 16'h0042; vb[j] = 16'h0042; end
    run_op(7, 6, 0);
    checks++; if (consumed !== 4 || nres !== 4) begin errors++; $display("FAIL clamp_len: consumed %0d results %0d exp 4 4", consumed, nres); end
    checks++; if (got_psw !== 16'h0003) begin errors++; $display("FAIL clamp_psw: got %h exp 0003", got_psw); end
  endtask
  task automatic test_reset_mid;
    @(negedge clk);
    start = 1; num_words = 3'd4;
    @(negedge clk);
    start = 0; op_valid = 1; a_in = 16'h0000; b_in = 16'h0001; res_ready = 1;
    @(negedge clk);
    @(negedge clk);
    op_valid = 0; rst_n = 0;
    @(negedge clk);
    checks++; if (busy !== 1'b0 || op_ready !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL mid_reset_ctrl: busy %b op_ready %b done %b exp 0 0 0", busy, op_ready, done); end
    checks++; if (res_valid !== 1'b0 || result !== 16'h0000) begin errors++; $display("FAIL mid_reset_res: valid %b result %h exp 0 0000", res_valid, result); end
    checks++; if (psw_out !== 16'h0000 || psw_msk !== 16'h0000) begin errors++; $display("FAIL mid_reset_psw: %h %h exp 0000 0000", psw_out, psw_msk); end
    rst_n = 1;
    va[0] = 16'h0005; vb[0] = 16'h0005;
    run_op(1, 1, 0);
    checks++; if (got[0] !== 16'h0000) begin errors++; $display("FAIL post_reset_result: got %h exp 0000", got[0]); end
    checks++; if (got_psw !== 16'h0003 || ndone !== 1) begin errors++; $display("FAIL post_reset_psw: got %h done %0d exp 0003 1", got_psw, ndone); end
  endtask
  initial begin
    test_reset;
    test_single;
    test_borrow_chain;
    test_zero_borrow;
    test_overflow;
    test_backpressure;
    test_clamp;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_sub_seq.md
# alu_sub_seq

Multi-precision subtract sequencer for the XM23 execute stage. Streams up to MAX_WORDS 16-bit operand pairs, least-significant word first, through one 16-bit subtract-with-borrow datapath. Chains the borrow between words and emits one result word per accepted operand pair. Presents the final PSW flag update with its write mask for the PSW register.

## Interface
- MAX_WORDS, 4: maximum operand length in 16-bit words (2..8).
- CNT_W, $clog2(MAX_WORDS+1): width of `num_words`.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- start  in  1  begin operation; sampled only when `busy`=0.
- num_words  in  CNT_W  operand length in words; 0 treated as 1; values >MAX_WORDS clamp to MAX_WORDS.
- busy  out  1  high from the cycle after `start` acceptance through the `done` cycle.
- op_valid  in  1  operand pair valid.
- op_ready  out  1  sequencer can accept an operand pair.
- a_in  in  16  minuend word.
- b_in  in  16  subtrahend word.
- res_valid  out  1  `result` holds a valid word.
- res_ready  in  1  consumer accepts `result`.
- result  out  16  difference word.
- done  out  1  one-cycle pulse; `psw_out`/`psw_msk` valid.
- psw_out  out  16  flag values: C=bit0, Z=bit1, N=bit2, V=bit4, all other bits 0.
- psw_msk  out  16  16'h0017 while `done`=1, else 16'h0000.

## Operation
- FSM states: IDLE, RUN, FLUSH, DONE.
- IDLE: `op_ready`=0. On `start`: latch the clamped length into `remaining`, set `borrow`=0 and `zacc`=1, then go to RUN.
- RUN: `op_ready` = !res_valid || res_ready, giving a one-entry output register with pass-through refill.
- On an operand handshake, compute {bout, d} = {1'b0,a_in} - {1'b0,b_in} - borrow. Then:
  - register `result`=d and set `res_valid`;
  - set `borrow`=bout;
  - set `zacc` = zacc & (d==0);
  - decrement `remaining`.
- On the final word, also latch `n`=d[15] and `v`=(a_in[15]!=b_in[15]) && (d[15]!=a_in[15]), then go to FLUSH.
- FLUSH: `op_ready`=0. When the last `result` is accepted (res_valid && res_ready), go to DONE.
- DONE: for one cycle, `done`=1, `psw_out` = {11'b0, v, 1'b0, n, zacc, ~borrow}, `psw_msk`=16'h0017. Return to IDLE.
- Carry convention: C = NOT borrow. C=1 means no borrow, matching XM23 SUB/CMP.
- Z covers all result words. N and V come from the most significant word only.
- `res_valid` clears on acceptance unless refilled the same cycle.
- `start` while `busy`=1 is ignored.
- `op_valid` in IDLE, FLUSH or DONE is ignored, since `op_ready`=0.

## Timing
- Reset (rst_n=0 at an edge): state=IDLE, busy=0, op_ready=0, res_valid=0, result=0, done=0, psw_out=0, psw_msk=0, borrow=0, zacc=1.
- Operand to result latency is 1 cycle. Throughput is 1 word/cycle with `res_ready` held high.
- `busy` rises the cycle after `start`. `op_ready` can be high in that same first RUN cycle.
- `done` is asserted the cycle after the final `result` handshake.
- With N words, no stalls and immediate acceptance: start edge, N operand cycles, 1 flush cycle, 1 done cycle.
- Backpressure: `res_ready`=0 with `res_valid`=1 forces `op_ready`=0. `result` and `res_valid` stay stable until accepted.
- Reset mid-operation aborts on the next edge. No `done` is produced and partial results are discarded.
- A new `start` is accepted in the cycle `done` is high? No. It is accepted only from IDLE (the cycle after `done`).

## Structure
- Package `xm23_pkg` holds:
  - PSW bit index constants PSW_C=0, PSW_Z=1, PSW_N=2, PSW_V=4;
  - mask constant PSW_ARITH_MSK=16'h0017;
  - the FSM state enum `sub_seq_state_t`.
- Sub-module `alu_sbc`: combinational 16-bit subtract-with-borrow. Inputs a, b, bin; outputs d, bout, v. It holds the word arithmetic so it can be reused by a future SBC instruction path.
- The top level holds the FSM, word counter, borrow/zero accumulators and output register.

## Test plan
- Single word: num_words=1, a=16'h0005, b=16'h0003 -> result 16'h0002, psw_out=16'h0001 (C=1), psw_msk=16'h0017.
- Borrow chain: num_words=2, words (LS,MS) a={16'h0000,16'h0001}, b={16'h0001,16'h0000} -> results 16'hFFFF, 16'h0000. psw_out=16'h0001: C=1, Z=0 because the LS word is nonzero.
- Zero and borrow: num_words=2, a=b={16'h1234,16'h8000} -> results 16'h0000, 16'h0000, psw_out=16'h0003. Then a={0,0}, b={1,0} -> results 16'hFFFF, 16'hFFFF, psw_out=16'h0004 (N=1, C=0).
- Overflow: num_words=1, a=16'h8000, b=16'h0001 -> result 16'h7FFF, psw_out=16'h0011 (V=1, C=1).
- Backpressure: num_words=4, res_ready low for 3 cycles after the first result -> `op_ready` low during the stall, all 4 results correct and in order, exactly one `done`. Also num_words=0 -> behaves as 1 word.
- Reset mid-run: assert rst_n=0 after 2 of 4 words -> next cycle all outputs at reset values. A subsequent 1-word operation completes correctly with borrow cleared.
